// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - program-launch controller feeding PC load strobe and start address
module prog_sequencer #(
    parameter logic [7:0]  START0     = 8'd0,
    parameter logic [7:0]  START1     = 8'd25,
    parameter logic [7:0]  START2     = 8'd44,
    parameter int unsigned MAX_CYCLES = 4095
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        halt,
    output logic [1:0]  prog_sel,
    output logic [7:0]  start_addr,
    output logic        pc_load,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] cycle_count
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [15:0] LAST_CNT = 16'(MAX_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic        pc_load_q, pc_load_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic [15:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= 2'd0;
            pc_load_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            pc_load_q <= pc_load_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    cnt_d     = 16'd0;
                    timeout_d = 1'b0;
                end
            end
            LOAD: state_d = RUN;
            RUN: begin
                cnt_d = cnt_q + 16'd1;
                // Halt takes priority over the limit when both land on the same edge.
                if (halt) begin
                    state_d   = DONE;
                    timeout_d = 1'b0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                    sel_d   = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Status outputs are registered images of the state being entered.
        pc_load_d = (state_d == LOAD);
        busy_d    = (state_d == LOAD) || (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    always_comb begin
        case (sel_q)
            2'd1:    start_addr = START1;
            2'd2:    start_addr = START2;
            default: start_addr = START0;
        endcase
    end

    assign prog_sel    = sel_q;
    assign pc_load     = pc_load_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - directed vector bench for prog_sequencer
module tb_prog_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic [1:0]  prog_sel;
    logic [7:0]  start_addr;
    logic        pc_load;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_count;

    int errors = 0;
    int checks = 0;
    int pc_load_cnt = 0;
    int pc_load_double = 0;
    logic pc_load_prev = 1'b0;

    prog_sequencer #(
        .START0(8'd0), .START1(8'd25), .START2(8'd44), .MAX_CYCLES(20)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .prog_sel(prog_sel), .start_addr(start_addr), .pc_load(pc_load),
        .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pc_load) pc_load_cnt <= pc_load_cnt + 1;
        if (pc_load && pc_load_prev) pc_load_double <= pc_load_double + 1;
        pc_load_prev <= pc_load;
    end

    typedef struct {
        logic        s, h;
        logic        pl, b, d, t;
        logic [1:0]  sel;
        logic [7:0]  addr;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic s, logic h, logic pl, logic b, logic d, logic t,
                                logic [1:0] sel, logic [7:0] addr, logic [15:0] cnt);
        vec_t v;
        v.s = s; v.h = h; v.pl = pl; v.b = b; v.d = d; v.t = t;
        v.sel = sel; v.addr = addr; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_prog(input int halt_at, input logic [1:0] esel, input logic [7:0] eaddr,
                            input int ecnt, input logic eto, input int hold);
        int loads;
        int w;
        start = 1'b1;
        halt  = 1'b0;
        @(negedge clk);
        chk("launch_pc_load", pc_load, 1);
        chk("launch_addr", start_addr, eaddr);
        chk("launch_sel", prog_sel, esel);
        loads = pc_load_cnt + 1;
        @(negedge clk);
        chk("run1_pc_load", pc_load, 0);
        for (int k = 2; k <= halt_at; k++) @(negedge clk);
        if (halt_at > 0) halt = 1'b1;
        w = 0;
        while (!done && w < 100) begin
            @(negedge clk);
            halt = 1'b0;
            w++;
        end
        chk("done_reached", done, 1);
        chk("done_busy", busy, 0);
        chk("done_cnt", cycle_count, ecnt);
        chk("done_timeout", timeout, eto);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_done", done, 1);
        end
        chk("hold_sel", prog_sel, esel);
        chk("hold_no_relaunch", pc_load_cnt, loads);
        start = 1'b0;
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_sel", prog_sel, (esel == 2'd2) ? 2'd0 : esel + 2'd1);
    endtask

    initial begin
        // Async reset before any clock edge
        #3 reset = 1'b1;
        #1;
        chk("rst_sel", prog_sel, 0);
        chk("rst_addr", start_addr, 0);
        chk("rst_pc_load", pc_load, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cnt", cycle_count, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) begin
            halt = ~halt;
            @(negedge clk);
            chk("idle_busy", busy, 0);
        end
        halt = 1'b0;
        chk("idle_no_load", pc_load_cnt, 0);

        // Single run, halt in the 7th RUN cycle
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0));
        for (int c = 1; c <= 6; c++) vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 16'(c)));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 7));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 7));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 25, 7));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 25, 7));
        foreach (vecs[i]) begin
            start = vecs[i].s;
            halt  = vecs[i].h;
            @(negedge clk);
            chk($sformatf("v%0d_pc_load", i), pc_load, vecs[i].pl);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].b);
            chk($sformatf("v%0d_done", i), done, vecs[i].d);
            chk($sformatf("v%0d_timeout", i), timeout, vecs[i].t);
            chk($sformatf("v%0d_sel", i), prog_sel, vecs[i].sel);
            chk($sformatf("v%0d_addr", i), start_addr, vecs[i].addr);
            chk($sformatf("v%0d_cnt", i), cycle_count, vecs[i].cnt);
        end
        start = 1'b0;
        halt  = 1'b0;

        // Back to program 0, then full rotation plus timeout cases
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_prog(3, 2'd0, 8'd0, 3, 1'b0, 0);
        run_prog(5, 2'd1, 8'd25, 5, 1'b0, 0);
        run_prog(2, 2'd2, 8'd44, 2, 1'b0, 0);
        run_prog(0, 2'd0, 8'd0, 20, 1'b1, 0);
        run_prog(20, 2'd1, 8'd25, 20, 1'b0, 0);
        run_prog(4, 2'd2, 8'd44, 4, 1'b0, 15);
        run_prog(2, 2'd0, 8'd0, 2, 1'b0, 0);

        // Reset in the 4th RUN cycle of program 1
        start = 1'b1;
        @(negedge clk);
        chk("mr_launch_addr", start_addr, 25);
        repeat (4) @(negedge clk);
        chk("mr_busy_before", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("mr_sel", prog_sel, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_cnt", cycle_count, 0);
        chk("mr_addr", start_addr, 0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mr_idle_done", done, 0);
        run_prog(3, 2'd0, 8'd0, 3, 1'b0, 0);

        chk("pc_load_single_cycle", pc_load_double, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Program-launch controller sitting directly upstream of the program counter. It sequences the three resident programs (product, string match, closest pair) by cycling through them. For each launch it produces the one-cycle load strobe and start address that the PC consumes. It watches for the decoder's halt indication, measures run length in cycles, and returns a done/timeout handshake to the test harness.

## Interface
- `START0`, default 0: PC start address of program 0 (product).
- `START1`, default 25: PC start address of program 1 (string match).
- `START2`, default 44: PC start address of program 2 (closest pair).
- `MAX_CYCLES`, default 4095: RUN-cycle limit before a forced timeout; must be ≥ 1 and ≤ 65535.
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high; returns every register to its reset value immediately.
- `start`, input, 1: level request from the harness to launch the current program.
- `halt`, input, 1: from the decoder; high in the cycle a HALT instruction is fetched.
- `prog_sel`, output, 2: index of the current/next program (0..2).
- `start_addr`, output, 8: START0/1/2 selected by `prog_sel`; feeds the PC load value.
- `pc_load`, output, 1: one-cycle strobe that drives the PC's load/reset input.
- `busy`, output, 1: high in LOAD and RUN.
- `done`, output, 1: high while in DONE.
- `timeout`, output, 1: high in DONE if the run ended by the cycle limit.
- `cycle_count`, output, 16: RUN cycles of the current/last run.

## Operation
- Reset values:
  - FSM state IDLE.
  - `prog_sel` = 0.
  - `pc_load`, `busy`, `done`, and `timeout` = 0.
  - `cycle_count` = 0.
  - `start_addr` = START0.
- All outputs are registered, except `start_addr`, which is a pure decode of registered `prog_sel`.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - `start`=1 → LOAD. On that same edge, clear `cycle_count` and `timeout`.
  - `halt` is ignored.
- LOAD:
  - Lasts exactly one cycle; `pc_load`=1 and `busy`=1.
  - Always moves to RUN.
  - `start` and `halt` are ignored.
- RUN:
  - `busy`=1.
  - Each cycle, `cycle_count` increments by 1, counting the halt cycle too.
  - If `halt`=1 → DONE, with `timeout` = 0.
  - Else if `cycle_count` == MAX_CYCLES−1 on this edge, the count becomes MAX_CYCLES and the FSM goes to DONE with `timeout` = 1.
  - `start` is ignored.
- DONE:
  - `done`=1; `cycle_count` and `timeout` are frozen.
  - When `start`=0 → IDLE, and on the same edge `prog_sel` advances: 0→1→2→0 (wraps after 2; value 3 never occurs).
  - While `start` stays 1, the FSM remains in DONE. Holding `start` never causes a relaunch.
- Halt and limit in the same cycle: halt wins and `timeout` = 0.
- Reset mid-operation (any state): return to IDLE with `prog_sel` = 0. This abandons the run sequence; no `done` is produced.
- `cycle_count` never wraps, because MAX_CYCLES ≤ 65535 bounds it.

## Timing
- `start` is sampled high at edge E0 in IDLE:
  - LOAD occupies cycle E0→E1, with `pc_load`=1 and `busy`=1.
  - The PC samples `pc_load` at E1 and loads `start_addr`, so PC = start_addr in the first RUN cycle (E1→E2).
- `halt` is sampled high at edge Eh in RUN: `done`=1 and `busy`=0 starting after Eh.
- `start` is sampled low at Ed in DONE: `done`=0 and the new `prog_sel` take effect after Ed. The earliest relaunch is the sample on the next edge.
- `pc_load` is never high for more than one consecutive cycle.
- `start_addr` is stable for the entire LOAD and RUN period.

## Test plan
- Reset then idle: assert `reset` asynchronously mid-cycle. Outputs go to reset values without a clock edge: `start_addr`=0, `prog_sel`=0. Release reset and hold `start`=0 for 10 cycles; the FSM stays in IDLE and `pc_load` never pulses.
- Single run: raise `start`, then pulse `halt` in the 7th RUN cycle. Expect:
  - `pc_load` high for exactly 1 cycle, with `start_addr`=0.
  - `done`=1, `cycle_count`=7, `timeout`=0.
  - After `start` drops: `prog_sel`=1 and `start_addr`=25.
- Full rotation: run three programs with halts at 3, 5, and 2 cycles. Expect `start_addr` at each `pc_load` to be 0, 25, 44; the fourth launch uses `start_addr`=0 with `prog_sel`=0.
- Timeout: build with MAX_CYCLES=20 and never assert halt. Expect `done`=1, `timeout`=1, `cycle_count`=20. A variant raises `halt` in the 20th cycle and expects `timeout`=0 and `cycle_count`=20.
- Handshake hold: keep `start`=1 for 15 cycles after `done`. The FSM stays in DONE with no second `pc_load`, and `prog_sel` is unchanged until `start`=0.
- Reset mid-run: launch program 1, then assert `reset` in the 4th RUN cycle. Expect immediate IDLE with `prog_sel`=0, `busy`=0, `done`=0, `cycle_count`=0; the next launch loads `start_addr`=0.
